sparc_ifu_wayalloc: RTL and testbench
=====================================

Name: sparc_ifu_wayalloc

Overview:
- Icache fill-way allocator for the IFU miss path; sits directly downstream of the 5-bit replacement LFSR and consumes its 2-bit random output.
- For each icache miss it picks the way to fill:
  - An invalid way is used first.
  - Otherwise the LFSR-selected way is used, steered away from ways already pending fill for the same set by other threads.
- It tracks one outstanding fill per thread (4 threads) until the fill completes, and issues the LFSR advance request.

Parameters:
IDX_W, 7, icache set index width

Ports:
clk  input  1  core clock
reset  input  1  reset, synchronous, active-high
lfsr_out  input  2  random way from replacement LFSR
lfsr_advance  output  1  one-cycle pulse; LFSR steps next edge
req_vld  input  1  miss allocation request
req_tid  input  2  requesting thread
req_set  input  IDX_W  miss set index
req_way_vld  input  4  valid bits of the 4 ways in req_set
req_rdy  output  1  request accepted when req_vld & req_rdy
alloc_vld  output  1  one-cycle pulse: allocation result valid
alloc_tid  output  2  thread of result
alloc_way  output  2  selected fill way
fill_done  input  1  fill for fill_tid complete
fill_tid  input  2  thread whose fill completed
pend_vld  output  4  per-thread pending-fill flags

Behaviour:
- Pending table: 4 entries {vld, set[IDX_W-1:0], way[1:0]}, one per tid.
- FSM states: IDLE, PICK, ALLOC.
  - IDLE: req_rdy = ~pend_vld[req_tid], and 0 during reset. On accept, register tid, set and way_vld, then go to PICK.
  - A request for a tid with a pending entry is held (req_rdy=0) until that entry clears.
  - PICK: compute the way, write the table entry (vld=1), register alloc_way, then go to ALLOC.
  - ALLOC: alloc_vld=1 with alloc_tid/alloc_way, then go to IDLE.
  - Latency: accept at edge N; alloc_vld high in cycle N+2 for exactly one cycle. Maximum throughput is 1 request per 3 cycles.
- Blocked mask (PICK): blk[w]=1 if some other tid t≠tid has vld, set==req set and way==w.
  - The mask uses the table after this cycle's fill_done clear, so fill_done is bypassed.
- Selection:
  - inv = ~way_vld & ~blk.
  - If inv≠0, pick the lowest-index set bit of inv; lfsr_advance=0.
  - Else r=lfsr_out: pick the first unblocked of r, r+1, r+2, r+3 (mod 4). lfsr_advance=1 for that PICK cycle only.
  - At most 3 ways are blocked, so a way always exists.
  - Invalid-but-blocked ways are not chosen by the invalid path.
- fill_done: clears entry fill_tid at the edge and has no effect if that entry is already clear.
  - fill_done for tid X in the same cycle PICK writes X cannot occur, because X is held via req_rdy; if it does occur, the PICK write wins.
- pend_vld[t] = table vld[t], registered.
- Reset:
  - FSM returns to IDLE and all table entries are cleared.
  - Outputs go to 0: lfsr_advance, req_rdy, alloc_vld, alloc_tid, alloc_way, pend_vld.
  - Reset mid-operation abandons the in-flight request with no alloc_vld.
- All way arithmetic is 2-bit modulo-4 wrap (3+1=0).

Test Plan:
- Reset then req tid0 set=0x05 way_vld=4'b1011 -> alloc_vld two cycles after accept, alloc_way=2, lfsr_advance=0, pend_vld=4'b0001.
- All ways valid, lfsr_out=2'b11, no pending -> alloc_way=3, lfsr_advance pulses exactly once, in the PICK cycle.
- tid1 pending set=0x05 way 3; tid2 req set=0x05 way_vld=4'hF lfsr_out=3 -> alloc_way=0 (wrap). Same case with tid1 on set 0x06 -> alloc_way=3.
- tids 0,1,2 pending set 0x10 ways 0,1,2; tid3 req set 0x10 way_vld=4'hF lfsr_out=0 -> alloc_way=3.
- tid0 pending; req tid0 -> req_rdy=0 until fill_done tid0, then accepted next cycle. fill_done tid1 coincident with tid2 PICK on the same set/way -> way not blocked.
- Assert reset in the PICK cycle -> no alloc_vld, pend_vld=0, req_rdy=0 during reset, 1 the cycle after.

Source files
------------

// File: rtl/sparc_ifu_wayalloc.sv
// Icache fill-way allocator: picks an invalid way first, else an LFSR-chosen way
// steered around ways other threads already have pending for the same set.
module sparc_ifu_wayalloc #(
    parameter int IDX_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       lfsr_out,
    output logic             lfsr_advance,
    input  logic             req_vld,
    input  logic [1:0]       req_tid,
    input  logic [IDX_W-1:0] req_set,
    input  logic [3:0]       req_way_vld,
    output logic             req_rdy,
    output logic             alloc_vld,
    output logic [1:0]       alloc_tid,
    output logic [1:0]       alloc_way,
    input  logic             fill_done,
    input  logic [1:0]       fill_tid,
    output logic [3:0]       pend_vld
);

    typedef enum logic [1:0] {IDLE, PICK, ALLOC} state_t;

    state_t           r_state;
    logic [3:0]       r_vld;
    logic [IDX_W-1:0] r_set [4];
    logic [1:0]       r_way [4];
    logic [1:0]       r_tid;
    logic [IDX_W-1:0] r_reqSet;
    logic [3:0]       r_wayVld;
    logic             r_allocVld;
    logic [1:0]       r_allocTid;
    logic [1:0]       r_allocWay;

    logic [3:0] w_liveVld;
    logic [3:0] w_blk;
    logic [3:0] w_inv;
    logic [7:0] w_blk2;
    logic [3:0] w_rotBlk;
    logic [1:0] w_rotIdx;
    logic [1:0] w_pickWay;
    logic       w_useLfsr;

    function automatic logic [1:0] lowestSet(input logic [3:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else if (v[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    // A fill completing this cycle no longer blocks its way.
    assign w_liveVld = r_vld & ~(fill_done ? (4'b0001 << fill_tid) : 4'b0000);

    always_comb begin
        w_blk = 4'b0000;
        for (int t = 0; t < 4; t++) begin
            if ((2'(t) != r_tid) && w_liveVld[t] && (r_set[t] == r_reqSet))
                w_blk[r_way[t]] = 1'b1;
        end
    end

    assign w_inv     = ~r_wayVld & ~w_blk;
    assign w_useLfsr = (w_inv == 4'b0000);

    // Rotate the blocked mask so bit k corresponds to way lfsr_out+k.
    assign w_blk2    = {w_blk, w_blk};
    assign w_rotBlk  = w_blk2[lfsr_out +: 4];
    assign w_rotIdx  = lowestSet(~w_rotBlk);
    assign w_pickWay = w_useLfsr ? (lfsr_out + w_rotIdx) : lowestSet(w_inv);

    assign lfsr_advance = ~reset & (r_state == PICK) & w_useLfsr;
    assign req_rdy      = ~reset & (r_state == IDLE) & ~r_vld[req_tid];
    assign alloc_vld    = r_allocVld;
    assign alloc_tid    = r_allocTid;
    assign alloc_way    = r_allocWay;
    assign pend_vld     = r_vld;

    // The PICK write follows the fill clear so it wins on a same-tid collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_vld      <= 4'b0000;
            r_tid      <= 2'd0;
            r_reqSet   <= '0;
            r_wayVld   <= 4'b0000;
            r_allocVld <= 1'b0;
            r_allocTid <= 2'd0;
            r_allocWay <= 2'd0;
            for (int t = 0; t < 4; t++) begin
                r_set[t] <= '0;
                r_way[t] <= 2'd0;
            end
        end else begin
            r_allocVld <= 1'b0;
            if (fill_done)
                r_vld[fill_tid] <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_vld && req_rdy) begin
                        r_tid    <= req_tid;
                        r_reqSet <= req_set;
                        r_wayVld <= req_way_vld;
                        r_state  <= PICK;
                    end
                end
                PICK: begin
                    r_vld[r_tid] <= 1'b1;
                    r_set[r_tid] <= r_reqSet;
                    r_way[r_tid] <= w_pickWay;
                    r_allocVld   <= 1'b1;
                    r_allocTid   <= r_tid;
                    r_allocWay   <= w_pickWay;
                    r_state      <= ALLOC;
                end
                ALLOC:   r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sparc_ifu_wayalloc.sv
// Bench for sparc_ifu_wayalloc: directed scenarios plus random traffic, all
// checked every cycle against a transaction-level reference model.
module tb_sparc_ifu_wayalloc;

    localparam int IDX_W = 7;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       lfsr_out = '0;
    logic             lfsr_advance;
    logic             req_vld = 1'b0;
    logic [1:0]       req_tid = '0;
    logic [IDX_W-1:0] req_set = '0;
    logic [3:0]       req_way_vld = '0;
    logic             req_rdy;
    logic             alloc_vld;
    logic [1:0]       alloc_tid;
    logic [1:0]       alloc_way;
    logic             fill_done = 1'b0;
    logic [1:0]       fill_tid = '0;
    logic [3:0]       pend_vld;

    always #5 clk = ~clk;

    sparc_ifu_wayalloc #(.IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset), .lfsr_out(lfsr_out), .lfsr_advance(lfsr_advance),
        .req_vld(req_vld), .req_tid(req_tid), .req_set(req_set), .req_way_vld(req_way_vld),
        .req_rdy(req_rdy), .alloc_vld(alloc_vld), .alloc_tid(alloc_tid), .alloc_way(alloc_way),
        .fill_done(fill_done), .fill_tid(fill_tid), .pend_vld(pend_vld)
    );

    int testsRun = 0;
    int testsFailed = 0;

    // Reference model: pending fills per thread and the age of the in-flight request
    // (0 none, 1 = way being chosen this cycle, 2 = result presented this cycle).
    bit mKnown = 0;
    bit mJustReset = 0;
    bit mPend [4];
    int mSet [4];
    int mWay [4];
    int mAge = 0;
    int mTid, mReqSet, mWv, mAllocWay;

    int obsRdy, obsAdv, obsAllocVld, obsAllocWay, obsAllocTid, obsPend;

    task automatic checkOutput(input string tag, input int obs, input int exp);
        testsRun++;
        if (obs != exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int refChoose(input int tid, input int setIdx, input int wv, input int r,
                                     input bit fd, input int ftid, output bit usedLfsr);
        bit blocked [4];
        for (int w = 0; w < 4; w++) blocked[w] = 0;
        for (int t = 0; t < 4; t++)
            if (t != tid && mPend[t] && !(fd && ftid == t) && mSet[t] == setIdx)
                blocked[mWay[t]] = 1;
        usedLfsr = 0;
        for (int w = 0; w < 4; w++)
            if (((wv >> w) & 1) == 0 && !blocked[w]) return w;
        usedLfsr = 1;
        for (int k = 0; k < 4; k++)
            if (!blocked[(r + k) % 4]) return (r + k) % 4;
        return -1;
    endfunction

    task automatic stepCycle(input bit rst, input bit vld, input int tid, input int setIdx,
                             input int wv, input int lf, input bit fd, input int ftid);
        bit expRdy, used;
        int choice, pk;
        @(negedge clk);
        reset = rst; req_vld = vld; req_tid = 2'(tid); req_set = IDX_W'(setIdx);
        req_way_vld = 4'(wv); lfsr_out = 2'(lf); fill_done = fd; fill_tid = 2'(ftid);
        #1;
        obsRdy = int'(req_rdy); obsAdv = int'(lfsr_advance); obsAllocVld = int'(alloc_vld);
        obsAllocWay = int'(alloc_way); obsAllocTid = int'(alloc_tid); obsPend = int'(pend_vld);
        expRdy = !rst && mKnown && mAge == 0 && !mPend[tid];
        choice = -1; used = 0;
        if (mKnown && mAge == 1) choice = refChoose(mTid, mReqSet, mWv, lf, fd, ftid, used);
        if (rst || mKnown) begin
            checkOutput("reqRdy", obsRdy, int'(expRdy));
            checkOutput("lfsrAdvance", obsAdv, int'(!rst && mKnown && mAge == 1 && used));
        end
        if (mKnown) begin
            pk = 0;
            for (int t = 0; t < 4; t++) pk |= int'(mPend[t]) << t;
            checkOutput("pendVld", obsPend, pk);
            checkOutput("allocVld", obsAllocVld, int'(mAge == 2));
            if (mAge == 2) begin
                checkOutput("allocTid", obsAllocTid, mTid);
                checkOutput("allocWay", obsAllocWay, mAllocWay);
            end
            if (mJustReset) begin
                checkOutput("rstAllocTid", obsAllocTid, 0);
                checkOutput("rstAllocWay", obsAllocWay, 0);
            end
        end
        if (rst) begin
            mKnown = 1; mJustReset = 1; mAge = 0;
            for (int t = 0; t < 4; t++) mPend[t] = 0;
        end else if (mKnown) begin
            mJustReset = 0;
            if (fd) mPend[ftid] = 0;
            if (mAge == 1) begin
                mPend[mTid] = 1; mSet[mTid] = mReqSet; mWay[mTid] = choice;
                mAllocWay = choice; mAge = 2;
            end else if (mAge == 2) begin
                mAge = 0;
            end else if (vld && expRdy) begin
                mTid = tid; mReqSet = setIdx; mWv = wv; mAge = 1;
            end
        end
    endtask

    task automatic reqFull(input int tid, input int setIdx, input int wv, input int lf,
                           input bit pickFd, input int pickFtid, input int expWay,
                           input int expAdv, input string tag);
        bit acc = 0;
        for (int i = 0; i < 20 && !acc; i++) begin
            stepCycle(0, 1, tid, setIdx, wv, lf, 0, 0);
            acc = (obsRdy == 1);
        end
        if (!acc) checkOutput({tag, "Accept"}, 0, 1);
        stepCycle(0, 0, 0, 0, 0, lf, pickFd, pickFtid);
        checkOutput({tag, "AdvPick"}, obsAdv, expAdv);
        stepCycle(0, 0, 0, 0, 0, lf, 0, 0);
        checkOutput({tag, "Vld"}, obsAllocVld, 1);
        checkOutput({tag, "Way"}, obsAllocWay, expWay);
        checkOutput({tag, "AdvAlloc"}, obsAdv, 0);
    endtask

    task automatic clearAll();
        for (int t = 0; t < 4; t++) stepCycle(0, 0, 0, 0, 0, 0, 1, t);
    endtask

    initial begin
        stepCycle(1, 0, 0, 0, 0, 0, 0, 0);
        stepCycle(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rstRdyLow", obsRdy, 0);
        stepCycle(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rstRdy", obsRdy, 1);
        checkOutput("rstPend", obsPend, 0);

        reqFull(0, 5, 4'b1011, 0, 0, 0, 2, 0, "invWay");
        stepCycle(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("invPend", obsPend, 1);
        clearAll();

        reqFull(0, 5, 4'hF, 3, 0, 0, 3, 1, "lfsrWay");
        clearAll();

        reqFull(1, 5, 4'b0111, 0, 0, 0, 3, 0, "blkSetup");
        reqFull(2, 5, 4'hF, 3, 0, 0, 0, 1, "blkWrap");
        clearAll();
        reqFull(1, 6, 4'b0111, 0, 0, 0, 3, 0, "otherSetup");
        reqFull(2, 5, 4'hF, 3, 0, 0, 3, 1, "otherSet");
        clearAll();

        reqFull(0, 16, 4'b1110, 0, 0, 0, 0, 0, "three0");
        reqFull(1, 16, 4'b1101, 0, 0, 0, 1, 0, "three1");
        reqFull(2, 16, 4'b1011, 0, 0, 0, 2, 0, "three2");
        reqFull(3, 16, 4'hF, 0, 0, 0, 3, 1, "three3");
        clearAll();

        reqFull(0, 5, 4'hF, 0, 0, 0, 0, 1, "holdSetup");
        for (int i = 0; i < 3; i++) begin
            stepCycle(0, 1, 0, 9, 4'hF, 1, 0, 0);
            checkOutput("holdRdy", obsRdy, 0);
        end
        stepCycle(0, 1, 0, 9, 4'hF, 1, 1, 0);
        checkOutput("holdFillRdy", obsRdy, 0);
        stepCycle(0, 1, 0, 9, 4'hF, 1, 0, 0);
        checkOutput("holdRelease", obsRdy, 1);
        stepCycle(0, 0, 0, 0, 0, 1, 0, 0);
        stepCycle(0, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("holdWay", obsAllocWay, 1);
        clearAll();

        reqFull(1, 5, 4'b0111, 0, 0, 0, 3, 0, "bypSetup");
        reqFull(2, 5, 4'hF, 3, 1, 1, 3, 1, "bypass");
        clearAll();

        stepCycle(0, 1, 0, 5, 4'hF, 0, 0, 0);
        checkOutput("abortAccept", obsRdy, 1);
        stepCycle(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("abortRdy", obsRdy, 0);
        checkOutput("abortAdv", obsAdv, 0);
        stepCycle(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("abortVld", obsAllocVld, 0);
        checkOutput("abortPend", obsPend, 0);
        checkOutput("abortRdyAfter", obsRdy, 1);

        for (int i = 0; i < 3000; i++) begin
            stepCycle($urandom_range(0, 199) == 0, ($urandom % 4) != 0, $urandom_range(0, 3),
                      $urandom_range(5, 6), (($urandom % 2) != 0) ? 15 : $urandom_range(0, 15),
                      $urandom_range(0, 3), ($urandom % 4) == 0, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
